// File: rtl/dot_product_accum.sv
// Accumulation stage behind the dot-product multiplier: sums exactly `len` signed
// products into a wrapping accumulator, tracks sticky signed overflow, and holds the result on a valid/ready port.
module dot_product_accum #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  prod_vld,
    input  logic [DATA_WIDTH-1:0] prod,
    output logic [ACC_WIDTH-1:0]  res,
    output logic                  res_vld,
    input  logic                  res_rdy,
    output logic                  ovf,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [ACC_WIDTH-1:0]   acc_r;
    logic [LEN_WIDTH-1:0]   cnt_r;
    logic [ACC_WIDTH-1:0]   res_r;
    logic                   ovf_r;
    logic                   res_vld_r;
    logic                   busy_r;

    logic signed [DATA_WIDTH-1:0] prod_sg_s;
    logic [ACC_WIDTH-1:0]   prod_ext_s;
    logic [ACC_WIDTH-1:0]   sum_s;
    logic                   ovf_step_s;
    logic                   last_s;
    logic                   accept_s;
    logic                   res_vld_nxt_s;
    logic                   busy_nxt_s;

    // Sign-extended sum and overflow of the current product against the accumulator.
    always_comb begin
        prod_sg_s  = prod;
        prod_ext_s = ACC_WIDTH'(prod_sg_s);
        sum_s      = acc_r + prod_ext_s;
        ovf_step_s = (acc_r[ACC_WIDTH-1] == prod_ext_s[ACC_WIDTH-1]) &&
                     (sum_s[ACC_WIDTH-1] != acc_r[ACC_WIDTH-1]);
        last_s     = (cnt_r == LEN_WIDTH'(1));
        accept_s   = ce && prod_vld && (state_r == ST_ACCUM);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero-length request goes straight to HOLD.
    always_comb begin
        state_nxt_s = state_r;
        if (ce) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = (len == LEN_WIDTH'(0)) ? ST_HOLD : ST_ACCUM;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s && last_s) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (res_rdy) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Status outputs decoded from the next state so they are registered yet change at the same edge as the state.
    always_comb begin
        res_vld_nxt_s = (state_nxt_s == ST_HOLD);
        busy_nxt_s    = (state_nxt_s != ST_IDLE);
    end

    // Status output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_vld_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            res_vld_r <= res_vld_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Accumulator, element counter, result and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            cnt_r <= {LEN_WIDTH{1'b0}};
            res_r <= {ACC_WIDTH{1'b0}};
            ovf_r <= 1'b0;
        end else if (ce) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r <= {ACC_WIDTH{1'b0}};
                        cnt_r <= len;
                        res_r <= {ACC_WIDTH{1'b0}};
                        ovf_r <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (prod_vld) begin
                        acc_r <= sum_s;
                        cnt_r <= cnt_r - LEN_WIDTH'(1);
                        ovf_r <= ovf_r | ovf_step_s;
                        if (last_s) begin
                            res_r <= sum_s;
                        end
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign res     = res_r;
    assign ovf     = ovf_r;
    assign res_vld = res_vld_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_dot_product_accum.sv
// Directed bench for dot_product_accum: a transaction-level model is checked every
// cycle, and hand-computed literals pin the key results.
module tb_dot_product_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = 16'd0;
    logic        prod_vld = 1'b0;
    logic [31:0] prod = 32'd0;
    logic [31:0] res;
    logic        res_vld;
    logic        res_rdy = 1'b0;
    logic        ovf;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    dot_product_accum #(.DATA_WIDTH(32), .ACC_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start), .len(len),
        .prod_vld(prod_vld), .prod(prod), .res(res), .res_vld(res_vld),
        .res_rdy(res_rdy), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: busy / result-waiting flags, remaining element count, exact integer sum.
    logic        m_busy = 1'b0;
    logic        m_vld  = 1'b0;
    logic [15:0] m_left = 16'd0;
    logic [31:0] m_acc  = 32'd0;
    logic [31:0] m_res  = 32'd0;
    logic        m_ovf  = 1'b0;

    function automatic longint exact_sum(input logic [31:0] a, input logic [31:0] b);
        return longint'($signed(a)) + longint'($signed(b));
    endfunction

    function automatic logic [31:0] wrap32(input longint s);
        logic [63:0] v;
        v = 64'(s);
        return v[31:0];
    endfunction

    function automatic logic out_of_range(input longint s);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_vld <= 1'b0; m_left <= 16'd0;
            m_acc <= 32'd0; m_res <= 32'd0; m_ovf <= 1'b0;
        end else if (ce) begin
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_vld  <= (len == 16'd0);
                    m_left <= len;
                    m_acc  <= 32'd0;
                    m_res  <= 32'd0;
                    m_ovf  <= 1'b0;
                end
            end else if (m_vld) begin
                if (res_rdy) begin
                    m_busy <= 1'b0;
                    m_vld  <= 1'b0;
                end
            end else if (prod_vld) begin
                m_acc  <= wrap32(exact_sum(m_acc, prod));
                m_ovf  <= m_ovf | out_of_range(exact_sum(m_acc, prod));
                m_left <= m_left - 16'd1;
                if (m_left == 16'd1) begin
                    m_res <= wrap32(exact_sum(m_acc, prod));
                    m_vld <= 1'b1;
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare; res/ovf are only meaningful outside accumulation.
    always @(negedge clk) begin
        cmp("busy", {31'd0, busy}, {31'd0, m_busy});
        cmp("res_vld", {31'd0, res_vld}, {31'd0, m_vld});
        if (!(m_busy && !m_vld)) begin
            cmp("res", res, m_res);
            cmp("ovf", {31'd0, ovf}, {31'd0, m_ovf});
        end
    end

    task automatic drv(input logic c, input logic s, input logic [15:0] l,
                       input logic pv, input logic [31:0] p, input logic rr);
        @(negedge clk);
        ce = c; start = s; len = l; prod_vld = pv; prod = p; res_rdy = rr;
    endtask

    task automatic idle(input logic rr);
        drv(1'b1, 1'b0, 16'd0, 1'b0, 32'd0, rr);
    endtask

    task automatic lit(input string nm, input logic [31:0] r, input logic v,
                       input logic o, input logic b);
        cmp({nm, "_res"}, res, r);
        cmp({nm, "_vld"}, {31'd0, res_vld}, {31'd0, v});
        cmp({nm, "_ovf"}, {31'd0, ovf}, {31'd0, o});
        cmp({nm, "_busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    task automatic handshake();
        idle(1'b1);
        idle(1'b0);
        cmp("hs_vld", {31'd0, res_vld}, 32'd0);
        cmp("hs_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        lit("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // 1,2,3,4 back to back
        drv(1'b1, 1'b1, 16'd4, 1'b0, 32'd0, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd1, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd2, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd3, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd4, 1'b0);
        idle(1'b0);
        lit("sum10", 32'd10, 1'b1, 1'b0, 1'b1);
        handshake();

        // -5, 7, -9 with gaps, a ce stall, and len changing mid-run
        drv(1'b1, 1'b1, 16'd3, 1'b0, 32'd0, 1'b0);
        drv(1'b1, 1'b0, 16'd1, 1'b1, 32'hFFFFFFFB, 1'b0);
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, 16'd1, 1'b1, 32'd100, 1'b1);
        drv(1'b1, 1'b0, 16'd9, 1'b1, 32'd7, 1'b0);
        idle(1'b0);
        idle(1'b0);
        cmp("gap_busy", {31'd0, busy}, 32'd1);
        cmp("gap_vld", {31'd0, res_vld}, 32'd0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'hFFFFFFF7, 1'b0);
        idle(1'b0);
        lit("neg7", 32'hFFFFFFF9, 1'b1, 1'b0, 1'b1);
        handshake();

        // len = 0, with product pulses in IDLE and HOLD
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd77, 1'b0);
        drv(1'b1, 1'b1, 16'd0, 1'b1, 32'd50, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd60, 1'b0);
        lit("len0", 32'd0, 1'b1, 1'b0, 1'b1);
        handshake();

        // overflow, then a clean run clears it
        drv(1'b1, 1'b1, 16'd2, 1'b0, 32'd0, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'h7FFFFFFF, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd1, 1'b0);
        idle(1'b0);
        lit("ovf", 32'h80000000, 1'b1, 1'b1, 1'b1);
        handshake();
        drv(1'b1, 1'b1, 16'd1, 1'b0, 32'd0, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd5, 1'b0);
        idle(1'b0);
        lit("five", 32'd5, 1'b1, 1'b0, 1'b1);
        handshake();

        // HOLD backpressure with start pulses; start during the handshake is dropped
        drv(1'b1, 1'b1, 16'd1, 1'b0, 32'd0, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b1, 16'd2, 1'b0, 32'd0, 1'b0);
            lit("hold", 32'd3, 1'b1, 1'b0, 1'b1);
        end
        drv(1'b1, 1'b1, 16'd2, 1'b0, 32'd0, 1'b1);
        idle(1'b0);
        lit("hs_start", 32'd3, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cmp("hs_start_busy2", {31'd0, busy}, 32'd0);

        // reset mid-ACCUM after 2 of 5 products
        drv(1'b1, 1'b1, 16'd5, 1'b0, 32'd0, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd10, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd20, 1'b0);
        idle(1'b0);
        #2 reset = 1'b1;
        #1 lit("rst_mid", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drv(1'b1, 1'b1, 16'd1, 1'b0, 32'd0, 1'b0);
        drv(1'b1, 1'b0, 16'd0, 1'b1, 32'd9, 1'b0);
        idle(1'b0);
        lit("nine", 32'd9, 1'b1, 1'b0, 1'b1);
        handshake();

        idle(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dot_product_accum.md
# dot_product_accum

Accumulation stage that sits directly downstream of the dot-product pipelined signed multiplier. It consumes one signed product per accepted cycle and sums exactly `len` products into a wrapping two's-complement accumulator. It tracks signed overflow and presents the final sum on a valid/ready result port. It shares the multiplier's `clk`/`ce`/`reset` and is the block that turns a product stream into a dot-product result.

## Interface
- `DATA_WIDTH`, 32: width of incoming product (multiplier `dout`).
- `ACC_WIDTH`, 32: accumulator/result width; must be ≥ `DATA_WIDTH`; product is sign-extended.
- `LEN_WIDTH`, 16: width of element-count input.

- `clk`, in, 1: single clock; all state changes on rising edge.
- `reset`, in, 1: asynchronous, active-high; forces every register to its reset value immediately.
- `ce`, in, 1: clock enable; when 0, all state is frozen and every input is ignored.
- `start`, in, 1: begin a new dot product; sampled only in IDLE.
- `len`, in, `LEN_WIDTH`: number of products to accumulate; sampled with `start`.
- `prod_vld`, in, 1: `prod` holds a valid product this cycle.
- `prod`, in, `DATA_WIDTH`: signed product.
- `res`, out, `ACC_WIDTH`: signed sum; stable while `res_vld`=1.
- `res_vld`, out, 1: result available.
- `res_rdy`, in, 1: downstream accepts result.
- `ovf`, out, `ACC_WIDTH`-independent 1 bit: sticky signed-overflow flag for this result; valid with `res_vld`.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- Accepted product: `ce`=1 and `prod_vld`=1 and state=ACCUM. A product is never accepted in IDLE or HOLD.
- State IDLE, on `ce` & `start`:
  - `acc`←0, `ovf`←0, `cnt`←`len`.
  - If `len`=0, go to HOLD with `res`=0. Otherwise go to ACCUM.
- State ACCUM, on an accepted product:
  - `acc`←`acc` + sext(`prod`), modulo 2^`ACC_WIDTH`.
  - `cnt`←`cnt`−1.
  - `ovf`←`ovf` | (operand signs equal and sum sign differs).
  - If the pre-decrement `cnt`=1, load `res`←new sum and go to HOLD.
  - Cycles with `prod_vld`=0 leave `acc` and `cnt` unchanged.
- State HOLD: `res_vld`=1.
  - On `ce` & `res_rdy`, go to IDLE.
  - `res` and `ovf` are held until the next `start` is accepted.
- `start` outside IDLE is ignored; there is no queuing.
- `start` in the same cycle as a HOLD handshake is ignored; `start` must be reissued in IDLE.
- The `len` value is captured only at `start`. Later changes to `len` have no effect.
- Reset values:
  - state=IDLE, `acc`=0, `cnt`=0.
  - Outputs: `res`=0, `res_vld`=0, `ovf`=0, `busy`=0.
- Reset asserted mid-ACCUM or mid-HOLD aborts the operation; no result is produced for it.

## Timing
- `start` accepted at edge T: `busy`=1 from T.
  - With `len`=0: `res_vld`=1 from T.
- Last product accepted at edge T: `res`/`res_vld` valid from T. Latency is one cycle from product presentation to result.
- `res_vld` falls at the edge where `ce` & `res_rdy`=1. Minimum HOLD duration is 1 cycle.
- Back-to-back throughput is `len`+2 cycles per result with `prod_vld` continuously high and `res_rdy`=1: 1 IDLE, `len` ACCUM, 1 HOLD.
- Upstream alignment: `prod_vld` must be driven aligned to multiplier `dout`, i.e. delayed one `ce`-qualified cycle from the multiplier input.
- `ce`=0 in any state: no transition, no accept, and no handshake completes. Outputs hold their values.

## Test plan
- `len`=4, products 1, 2, 3, 4 on consecutive cycles → `res`=10, `ovf`=0, `res_vld` high the cycle after `prod`=4 is accepted.
- `len`=3, products −5, 7, −9 with `prod_vld` gaps of 2 cycles and `ce`=0 for 3 cycles mid-stream → `res`=0xFFFFFFF9 (−7); product count unaffected by gaps or stalls.
- `len`=0 → `res`=0, `res_vld` one cycle after `start`. `prod_vld` pulses in IDLE and HOLD are not accumulated.
- `len`=2, products 0x7FFFFFFF, 1 → `res`=0x80000000, `ovf`=1. The next run with `len`=1, product 5 → `res`=5, `ovf`=0.
- `res_rdy` held low 4 cycles in HOLD with `start` pulsed → `res` stable, `res_vld`=1, `start` ignored. `res_rdy`=1 → IDLE next cycle.
- Assert `reset` mid-ACCUM after 2 of 5 products → all outputs 0 immediately. A new run with `len`=1, product 9 → `res`=9.
